tt_um_div_by_n_simeon_turner: RTL and testbench
===============================================

TT_UM_DIV_BY_N_SIMEON_TURNER -- requirements
Module: tt_um_div_by_n_simeon_turner

Interface
REQ-001 Parameter N_W, default 4, divisor/remainder width; legal range 2..4.
REQ-002 Parameter CNT_W, default 8, bit-counter width; legal range 1..8.
REQ-003 Parameter DIV_DEFAULT, default 5, divisor value loaded at reset; SHALL be below 2**N_W.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  always 1 when powered; SHALL be ignored.
REQ-007 ui_in  input  8  [0]=serial data bit (MSB first), [1]=bit strobe, [2]=clear, [3]=load divisor, [7:4]=divisor value (low N_W bits used).
REQ-008 uo_out  output  8  [N_W-1:0]=remainder, [4]=divisible, [5]=run, [6]=err, [7]=count saturated; unused bits between N_W and 4 SHALL be 0.
REQ-009 uio_in  input  8  unused.
REQ-010 uio_out  output  8  bit count, zero-extended from CNT_W.
REQ-011 uio_oe  output  8  SHALL be constant 8'hFF.

Function
REQ-012 ui_in[3:0] SHALL each pass through a 2-flop synchroniser; ui_in[7:4] SHALL be sampled directly at the load event.
REQ-013 Strobe, clear and load SHALL act only on the rising edge of their synchronised copies, detected by comparison with a third registered copy; a held-high input SHALL produce exactly one event.
REQ-014 Event latency: an input first sampled high at edge k SHALL update outputs at edge k+3.
REQ-015 State machine has two states: RUN and ERR.
REQ-016 Strobe event in RUN: remainder <= (2*remainder + bit) mod divisor, computed at width N_W+1 with at most one conditional subtraction; the count SHALL increment, saturating at 2**CNT_W-1.
REQ-017 Strobe event in ERR SHALL be ignored; remainder and count stay unchanged.
REQ-018 Load event: the divisor register SHALL be set to ui_in[N_W+3:4], remainder and count cleared; next state SHALL be ERR if the value is 0, otherwise RUN.
REQ-019 Clear event: remainder and count SHALL go to 0, divisor and state unchanged.
REQ-020 Simultaneous events: priority SHALL be load > clear > strobe; a lower-priority event in the same cycle SHALL be dropped.
REQ-021 Divisor 1: remainder SHALL stay 0 on every strobe.
REQ-022 divisible SHALL be 1 iff state is RUN, remainder is 0 and count is nonzero.
REQ-023 run SHALL be 1 in RUN; err SHALL be 1 in ERR.
REQ-024 Count saturated SHALL be 1 iff count equals 2**CNT_W-1; after saturation the remainder SHALL continue to update.
REQ-025 All outputs SHALL be driven from registers or from combinational decode of registers only, never directly from ui_in.

Reset
REQ-026 While rst_n is 0: state RUN, divisor = DIV_DEFAULT, remainder 0, count 0, all synchroniser flops 0.
REQ-027 Reset during operation SHALL discard any in-flight event; uo_out SHALL read 8'h20 and uio_out 8'h00 immediately.
REQ-028 On rst_n release, an input already held high SHALL NOT generate an event until it has been low for at least one sampled cycle.

Verification
REQ-029 Reset -> uo_out=8'h20, uio_out=8'h00, uio_oe=8'hFF.
REQ-030 Default divisor 5, strobe bits 1,0,1,0 -> remainder 1,2,0,0; divisible 0,0,1,1; final uio_out=4.
REQ-031 Load divisor 3, then bits 1,1,1 -> remainder 1,0,1; divisible only after the 2nd bit; load clears the count to 0.
REQ-032 Load divisor 0 -> err=1, run=0, uo_out=8'h40; 3 strobes leave count 0; load 7 -> uo_out=8'h20.
REQ-033 256 strobes of bit 0 -> uio_out=8'hFF, uo_out[7]=1, remainder 0, divisible 1.
REQ-034 Load and strobe rising in the same cycle -> divisor updated, bit dropped, count 0; assert rst_n low mid-sequence -> uo_out=8'h20 with no clock edge needed.

Source files
------------

// File: rtl/tt_um_div_by_n_simeon_turner.sv
// Serial divisibility checker: tracks (bitstream value) mod divisor, MSB first,
// with synchronised edge-detected strobe/clear/load controls and a bit counter.
module tt_um_div_by_n_simeon_turner #(
  parameter int N_W         = 4,
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   div_q, div_d;
  logic [N_W-1:0]   rem_q, rem_d, rem_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] s1, s2, s3;
  logic [3:1] armed;
  logic [3:1] evt_q;
  logic       seen;

  logic [N_W:0] shifted, div_ext, diff;

  wire unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

  // Controls arm only after a genuine low sample, so a line held high across
  // reset release cannot fire. The detected pulse is registered once more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      seen  <= 1'b0;
      armed <= '0;
      evt_q <= '0;
    end else begin
      s1    <= ui_in[3:0];
      s2    <= s1;
      s3    <= s2;
      seen  <= 1'b1;
      if (seen) armed <= armed | ~s1[3:1];
      evt_q <= s2[3:1] & ~s3[3:1] & armed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      div_q   <= N_W'(DIV_DEFAULT);
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // rem < div, so 2*rem+bit < 2*div and one subtraction reduces it.
  always_comb begin
    shifted  = {rem_q, s3[0]};
    div_ext  = {1'b0, div_q};
    diff     = shifted - div_ext;
    rem_next = (shifted >= div_ext) ? diff[N_W-1:0] : shifted[N_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (evt_q[3]) begin
      div_d   = ui_in[N_W+3:4];
      rem_d   = '0;
      cnt_d   = '0;
      state_d = (ui_in[N_W+3:4] == '0) ? ERR : RUN;
    end else if (evt_q[2]) begin
      rem_d = '0;
      cnt_d = '0;
    end else if (evt_q[1] && state_q == RUN) begin
      rem_d = rem_next;
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    uo_out           = '0;
    uo_out[N_W-1:0]  = rem_q;
    uo_out[4]        = (state_q == RUN) && (rem_q == '0) && (cnt_q != '0);
    uo_out[5]        = (state_q == RUN);
    uo_out[6]        = (state_q == ERR);
    uo_out[7]        = &cnt_q;
    uio_out          = '0;
    uio_out[CNT_W-1:0] = cnt_q;
  end

  assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_tt_um_div_by_n_simeon_turner.sv
// Bench for the serial divisibility checker: directed scenarios plus random
// operations, scored against an arithmetic model through an expected queue.
module tb_tt_um_div_by_n_simeon_turner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [23:0] exp_q[$];
  int          due_q[$];

  // Reference model state
  int   m_div, m_rem, m_cnt;
  logic m_err;

  tt_um_div_by_n_simeon_turner dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_reset();
    m_div = 5;
    m_rem = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] v);
    int d;
    d = int'(v[7:4]);
    if (v[3]) begin
      m_div = d;
      m_rem = 0;
      m_cnt = 0;
      m_err = (d == 0);
    end else if (v[2]) begin
      m_rem = 0;
      m_cnt = 0;
    end else if (v[1] && !m_err) begin
      m_rem = (2 * m_rem + int'(v[0])) % m_div;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end
  endfunction

  function automatic logic [23:0] model_out();
    logic [7:0] uo;
    logic [7:0] r;
    logic [7:0] c;
    r  = 8'(m_rem);
    c  = 8'(m_cnt);
    uo = {(m_cnt == 255), m_err, !m_err, (!m_err && m_rem == 0 && m_cnt != 0), r[3:0]};
    return {uo, c, 8'hFF};
  endfunction

  // Driver: the outputs must still show the old state two edges after the
  // first sample and the new state one edge later.
  task automatic apply(input logic [7:0] v);
    logic [23:0] old_e, new_e;
    int c0;
    @(negedge clk);
    c0    = cyc;
    old_e = model_out();
    model_step(v);
    new_e = model_out();
    exp_q.push_back(old_e); due_q.push_back(c0 + 3);
    exp_q.push_back(new_e); due_q.push_back(c0 + 4);
    ui_in = v;
    repeat (2) @(negedge clk);
    ui_in = {v[7:4], 4'b0000};
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_at(input int due);
    exp_q.push_back(model_out());
    due_q.push_back(due);
  endtask

  // Monitor / scoreboard
  always begin
    logic [23:0] e;
    int d;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      n_cmp++;
      if (uo_out !== 8'h20 || uio_out !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_outputs: got uo=%h uio=%h, want uo=20 uio=00", uo_out, uio_out);
      end
    end else begin
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        n_cmp++;
        if ({uo_out, uio_out, uio_oe} !== e) begin
          n_bad++;
          $display("FAIL cycle_%0d: got uo=%h uio=%h oe=%h, want uo=%h uio=%h oe=%h",
                   d, uo_out, uio_out, uio_oe, e[23:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_at(cyc + 1);
    repeat (2) @(negedge clk);

    // Default divisor 5, bits 1,0,1,0
    apply(8'h03); apply(8'h02); apply(8'h03); apply(8'h02);

    // Divisor 3, bits 1,1,1
    apply(8'h38);
    apply(8'h03); apply(8'h03); apply(8'h03);

    // Divisor 0 -> error, strobes ignored, then divisor 7
    apply(8'h08);
    apply(8'h03); apply(8'h02); apply(8'h03);
    apply(8'h78);

    // Clear, then saturate the counter
    apply(8'h04);
    for (int i = 0; i < 256; i++) apply(8'h02);
    apply(8'h03);
    apply(8'h03);

    // Load and strobe together; clear and strobe together
    apply(8'h3B);
    apply(8'h03);
    apply(8'h07);

    // Reset with a load in flight, strobe held high across release
    @(negedge clk);
    ui_in = 8'h5A;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    ui_in = 8'h02;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_at(cyc + 8);
    repeat (10) @(negedge clk);
    ui_in = 8'h00;
    repeat (3) @(negedge clk);
    apply(8'h03);
    apply(8'h03);

    // Random operations
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 99);
      v = 8'($urandom);
      if (k < 60)      v[3:1] = 3'b001;
      else if (k < 70) v[3:1] = 3'b010;
      else if (k < 85) v[3:1] = 3'b100;
      apply(v);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
